i2s_dac_tx: RTL and testbench

I2S_DAC_TX -- requirements
Module: i2s_dac_tx

---
 rtl/i2s_dac_tx_if.sv | 24 ++
 rtl/i2s_dac_tx.sv | 90 +++++++++
 tb/tb_i2s_dac_tx.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/i2s_dac_tx_if.sv
// Sample/control and codec-side signals of the I2S DAC transmitter.
// The master drives samples and controls; the slave (transmitter) drives the codec pins and status.
interface i2s_dac_tx_if;
    logic [31:0] sample_in;
    logic        sample_valid;
    logic        mute;
    logic        clear_flags;
    logic        bclk;
    logic        daclrck;
    logic        dacdat;
    logic        sample_req;
    logic        underrun;
    logic        overrun;

    modport master (
        output sample_in, sample_valid, mute, clear_flags,
        input  bclk, daclrck, dacdat, sample_req, underrun, overrun
    );

    modport slave (
        input  sample_in, sample_valid, mute, clear_flags,
        output bclk, daclrck, dacdat, sample_req, underrun, overrun
    );
endinterface

// File: rtl/i2s_dac_tx.sv
// I2S transmitter: serialises a 32-bit {left, right} frame with a one-bit delay, using a
// single-entry pending register fed by a strobe. Underrun and overrun are sticky flags.
module i2s_dac_tx #(
    parameter int unsigned BCLK_DIV = 16
) (
    input  logic          clk_i,
    input  logic          reset_i,
    i2s_dac_tx_if.slave   bus
);
    localparam int unsigned DivW = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;

    logic [DivW-1:0] div_q, div_d;
    logic            bclk_q, bclk_d;
    logic [4:0]      cnt_q, cnt_d;
    logic            lrck_q, lrck_d;
    logic            dat_q, dat_d;
    logic [31:0]     frame_q, frame_d;
    logic [31:0]     pend_q, pend_d;
    logic            full_q, full_d;
    logic            ur_q, ur_d;
    logic            or_q, or_d;

    logic            wrap, fall, load, set_ur, set_or;
    logic [31:0]     load_val;
    logic [4:0]      bit_idx;

    always_comb begin
        wrap   = (div_q == DivW'(BCLK_DIV - 1));
        fall   = wrap && bclk_q;
        load   = fall && (cnt_q == 5'd0);
        div_d  = wrap ? '0 : div_q + DivW'(1);
        bclk_d = bclk_q ^ wrap;
        cnt_d  = fall ? cnt_q + 5'd1 : cnt_q;

        // No pending sample means the previous frame is repeated.
        load_val = bus.mute ? 32'd0 : (full_q ? pend_q : frame_q);
        frame_d  = load ? load_val : frame_q;

        // Bit k of a word carries F[32-k]; k = 0 carries F[0] of the outgoing frame.
        bit_idx = 5'd0 - cnt_d;
        lrck_d  = fall ? cnt_d[4] : lrck_q;
        dat_d   = fall ? frame_d[bit_idx] : dat_q;

        // A load consumes the pending entry before a same-cycle strobe refills it.
        pend_d = pend_q;
        full_d = full_q && !load;
        if (bus.sample_valid) begin
            pend_d = bus.sample_in;
            full_d = 1'b1;
        end

        set_ur = load && !full_q;
        set_or = bus.sample_valid && full_q && !load;
        ur_d   = set_ur || (ur_q && !bus.clear_flags);
        or_d   = set_or || (or_q && !bus.clear_flags);
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            div_q   <= '0;
            bclk_q  <= 1'b0;
            cnt_q   <= 5'd0;
            lrck_q  <= 1'b0;
            dat_q   <= 1'b0;
            frame_q <= 32'd0;
            pend_q  <= 32'd0;
            full_q  <= 1'b0;
            ur_q    <= 1'b0;
            or_q    <= 1'b0;
        end else begin
            div_q   <= div_d;
            bclk_q  <= bclk_d;
            cnt_q   <= cnt_d;
            lrck_q  <= lrck_d;
            dat_q   <= dat_d;
            frame_q <= frame_d;
            pend_q  <= pend_d;
            full_q  <= full_d;
            ur_q    <= ur_d;
            or_q    <= or_d;
        end
    end

    assign bus.bclk       = bclk_q;
    assign bus.daclrck    = lrck_q;
    assign bus.dacdat     = dat_q;
    assign bus.sample_req = load;
    assign bus.underrun   = ur_q;
    assign bus.overrun    = or_q;
endmodule

// File: tb/tb_i2s_dac_tx.sv
// Bench for i2s_dac_tx: timeline-based reference model checked every cycle, plus directed
// scenarios with literal expectations for frames, flags and reset behaviour.
module tb_i2s_dac_tx;
    localparam int unsigned D = 16;
    localparam int         FrameCycles = 64 * D;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;

    i2s_dac_tx_if bus ();

    i2s_dac_tx #(.BCLK_DIV(D)) dut (
        .clk_i   (clk),
        .reset_i (reset),
        .bus     (bus)
    );

    always #10 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: n counts clk edges since reset release; everything follows from n.
    int          n;
    int          half, k;
    logic [31:0] m_frame, m_pend;
    bit          m_full, m_ur, m_or, ld, set_ur, set_or;
    logic        e_dat;

    always begin
        @(posedge clk);
        if (reset) begin
            n = 0; m_frame = '0; m_pend = '0; m_full = 0; m_ur = 0; m_or = 0;
        end else begin
            n++;
            ld = (n % FrameCycles) == 2 * D;
            set_ur = 0;
            set_or = 0;
            if (ld) begin
                if (!m_full) set_ur = 1;
                m_frame = bus.mute ? 32'd0 : (m_full ? m_pend : m_frame);
                m_full = 0;
            end
            if (bus.sample_valid) begin
                if (m_full) set_or = 1;
                m_pend = bus.sample_in;
                m_full = 1;
            end
            m_ur = set_ur || (m_ur && !bus.clear_flags);
            m_or = set_or || (m_or && !bus.clear_flags);
            #1;
            if (!reset) begin
                half  = n / D;
                k     = (half / 2) % 32;
                e_dat = (k == 0) ? m_frame[0] : m_frame[32 - k];
                check("bclk", bus.bclk, half % 2);
                check("daclrck", bus.daclrck, k >= 16);
                check("dacdat", bus.dacdat, e_dat);
                check("sample_req", bus.sample_req, ((n + 1) % FrameCycles) == 2 * D);
                check("underrun", bus.underrun, m_ur);
                check("overrun", bus.overrun, m_or);
            end
        end
    end

    task automatic wait_req(output int cycles);
        bit ok = 0;
        cycles = 0;
        while (!ok && cycles < 2 * FrameCycles) begin
            @(posedge clk);
            #1;
            cycles++;
            if (bus.sample_req) ok = 1;
        end
        check("req_seen", ok, 1);
    endtask

    task automatic capture_frame(output logic [31:0] f);
        int c;
        f = '0;
        wait_req(c);
        for (int i = 0; i < 32; i++) begin
            if (i == 0) @(posedge clk);
            else repeat (2 * D) @(posedge clk);
            #1;
            f = {f[30:0], bus.dacdat};
            if (i == 14) check("lrck_k15", bus.daclrck, 0);
            if (i == 15) check("lrck_k16", bus.daclrck, 1);
        end
    endtask

    task automatic pulse_valid(input logic [31:0] v);
        @(negedge clk);
        bus.sample_valid = 1'b1;
        bus.sample_in = v;
        @(negedge clk);
        bus.sample_valid = 1'b0;
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        bus.clear_flags = 1'b1;
        @(negedge clk);
        bus.clear_flags = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_bclk"}, bus.bclk, 0);
        check({tag, "_lrck"}, bus.daclrck, 0);
        check({tag, "_dat"}, bus.dacdat, 0);
        check({tag, "_req"}, bus.sample_req, 0);
        check({tag, "_ur"}, bus.underrun, 0);
        check({tag, "_or"}, bus.overrun, 0);
    endtask

    logic [31:0] f;
    int          c;

    initial begin
        bus.sample_in = '0;
        bus.sample_valid = 1'b0;
        bus.mute = 1'b0;
        bus.clear_flags = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");

        // First frame: sample staged before the first load.
        @(negedge clk);
        reset = 1'b0;
        bus.sample_valid = 1'b1;
        bus.sample_in = 32'hA5C3_0F81;
        @(negedge clk);
        bus.sample_valid = 1'b0;
        capture_frame(f);
        check("frame1", f, 32'hA5C3_0F81);
        check("frame1_ur", bus.underrun, 0);

        // Nothing staged: repeat and underrun, then clear.
        wait_req(c);
        @(posedge clk);
        #1;
        check("underrun_set", bus.underrun, 1);
        pulse_clear();
        check("underrun_clr", bus.underrun, 0);

        // Two strobes in one frame: overrun, the later sample wins.
        pulse_valid(32'h1111_2222);
        pulse_valid(32'h3333_4444);
        check("overrun_set", bus.overrun, 1);
        capture_frame(f);
        check("frame_overrun", f, 32'h3333_4444);
        pulse_clear();
        check("overrun_clr", bus.overrun, 0);

        // Strobe in the sample_req cycle with pending empty.
        wait_req(c);
        pulse_valid(32'h5A5A_1234);
        check("req_cycle_ur", bus.underrun, 1);
        check("req_cycle_or", bus.overrun, 0);
        capture_frame(f);
        check("frame_late", f, 32'h5A5A_1234);

        // Mute consumes the pending sample and sends zeros.
        @(negedge clk);
        bus.mute = 1'b1;
        pulse_clear();
        pulse_valid(32'hFFFF_FFFF);
        capture_frame(f);
        check("frame_mute", f, 32'h0000_0000);
        check("mute_ur", bus.underrun, 0);
        @(negedge clk);
        bus.mute = 1'b0;
        wait_req(c);
        @(posedge clk);
        #1;
        check("mute_consumed", bus.underrun, 1);

        // Reset at bit_cnt = 20 (19 falling edges after the load just seen).
        repeat (19 * 2 * D + 3) @(posedge clk);
        @(negedge clk);
        check("pre_reset_lrck", bus.daclrck, 1);
        reset = 1'b1;
        #1;
        check_all_zero("async_reset");
        repeat (2) @(negedge clk);
        reset = 1'b0;
        wait_req(c);
        check("req_after_reset", c, 2 * D - 1);
        repeat (4) @(posedge clk);
        #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
